// File: rtl/axis_pkt_player.sv
// axis_pkt_player
// ----------------
// AXI-Stream packet source. Beats are written into an internal buffer
// through the load port while idle, then replayed on m_axis one or more
// times with a programmable idle gap after every tlast beat.
//
// Ports
//   clk, aresetn                 clock, synchronous active-low reset
//   ld_valid/ld_ready            load handshake (IDLE only)
//   ld_data/ld_keep/ld_last      beat written at index beats_loaded
//   clear                        empty the buffer, clear err_unterm (IDLE only)
//   start                        begin replay (IDLE, non-empty buffer)
//   abort                        stop at the next packet boundary
//   gap_cycles                   tvalid-low cycles after each tlast (sampled at start)
//   repeat_cnt                   number of full-buffer passes, 0 means 1 (sampled at start)
//   play_tuser                   tuser for every beat (sampled at start)
//   m_axis_*                     replay stream
//   busy                         replay in progress
//   done                         one-cycle pulse on return to idle
//   aborted                      the last replay ended through abort; held until next start
//   err_unterm                   final buffered beat had no stored tlast; sticky
//   beats_loaded                 buffered beat count
//   pkts_sent                    accepted tlast beats since reset (wraps)
//
// Handshake: a beat transfers on any rising edge where valid && ready are
// both high. Once m_axis_tvalid is raised, tvalid and all payload fields
// stay constant until that transfer happens; only reset may cut a beat.

module axis_pkt_player #(
   parameter int DATA_WIDTH  = 512,
   parameter int TUSER_WIDTH = 128,
   parameter int DEPTH       = 64,
   parameter int GAP_WIDTH   = 16,
   parameter int REP_WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   input  logic [DATA_WIDTH/8-1:0]  ld_keep,
   input  logic                     ld_last,
   input  logic                     clear,
   input  logic                     start,
   input  logic                     abort,
   input  logic [GAP_WIDTH-1:0]     gap_cycles,
   input  logic [REP_WIDTH-1:0]     repeat_cnt,
   input  logic [TUSER_WIDTH-1:0]   play_tuser,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic                     err_unterm,
   output logic [$clog2(DEPTH):0]   beats_loaded,
   output logic [31:0]              pkts_sent
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int AW         = $clog2(DEPTH);
   localparam int CW         = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_PLAY,
      S_GAP
   } state_t;

   state_t state, state_nxt;

   // Beat buffer; contents are not reset.
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
   logic [DEPTH-1:0]      mem_last;

   logic [AW-1:0]          cur_idx;   // buffer index of the beat in the output register
   logic [REP_WIDTH-1:0]   pass;
   logic [REP_WIDTH-1:0]   rep_q;
   logic [GAP_WIDTH-1:0]   gap_q;
   logic [GAP_WIDTH-1:0]   gap_cnt;
   logic                   abort_q;

   logic                   ld_fire;
   logic                   start_fire;
   logic                   accept;
   logic [AW-1:0]          last_idx;
   logic                   cur_final;
   logic                   abort_now;

   // Control decoded by the next-state process
   logic                   rd_en;
   logic [AW-1:0]          rd_idx;
   logic                   tvalid_nxt;
   logic                   done_nxt;
   logic                   aborted_set;
   logic                   pass_inc;
   logic                   gap_load;

   assign ld_ready   = aresetn && (state == S_IDLE) && (beats_loaded < DEPTH_C) && !start && !clear;
   assign ld_fire    = ld_valid && ld_ready;
   // clear takes priority over start when both arrive together
   assign start_fire = (state == S_IDLE) && start && !clear && (beats_loaded != '0);
   assign accept     = m_axis_tvalid && m_axis_tready;
   assign last_idx   = AW'(beats_loaded - CW'(1));
   assign cur_final  = (cur_idx == last_idx);
   // abort raised in the very cycle of a boundary still counts
   assign abort_now  = abort_q || abort;
   assign busy       = (state != S_IDLE);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next state and datapath control
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      rd_en       = 1'b0;
      rd_idx      = cur_idx;
      tvalid_nxt  = m_axis_tvalid;
      done_nxt    = 1'b0;
      aborted_set = 1'b0;
      pass_inc    = 1'b0;
      gap_load    = 1'b0;
      case (state)
         S_IDLE: begin
            tvalid_nxt = 1'b0;
            if (start_fire) begin
               state_nxt = S_PRIME;
            end
         end
         S_PRIME: begin
            rd_en      = 1'b1;
            rd_idx     = '0;
            tvalid_nxt = 1'b1;
            state_nxt  = S_PLAY;
         end
         S_PLAY: begin
            if (accept) begin
               if (m_axis_tlast && ((cur_final && (pass >= rep_q)) || abort_now)) begin
                  state_nxt   = S_IDLE;
                  tvalid_nxt  = 1'b0;
                  done_nxt    = 1'b1;
                  aborted_set = abort_now;
               end else begin
                  // Fetch the following beat straight into the output
                  // register so accepted beats can issue every cycle.
                  rd_en    = 1'b1;
                  rd_idx   = cur_final ? '0 : cur_idx + AW'(1);
                  pass_inc = cur_final;
                  if (m_axis_tlast && (gap_q != '0)) begin
                     // Next beat is fetched now but held invisible for the gap.
                     state_nxt  = S_GAP;
                     tvalid_nxt = 1'b0;
                     gap_load   = 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            if (abort_now) begin
               state_nxt   = S_IDLE;
               done_nxt    = 1'b1;
               aborted_set = 1'b1;
            end else if (gap_cnt == GAP_WIDTH'(1)) begin
               state_nxt  = S_PLAY;
               tvalid_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            tvalid_nxt = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Buffer write port
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ld_fire) begin
         mem_data[beats_loaded[AW-1:0]] <= ld_data;
         mem_keep[beats_loaded[AW-1:0]] <= ld_keep;
         mem_last[beats_loaded[AW-1:0]] <= ld_last;
      end
   end

   // ---------------------------------------------------------------
   // Output register, counters and status
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         cur_idx       <= '0;
         pass          <= '0;
         rep_q         <= '0;
         gap_q         <= '0;
         gap_cnt       <= '0;
         abort_q       <= 1'b0;
         done          <= 1'b0;
         aborted       <= 1'b0;
         err_unterm    <= 1'b0;
         beats_loaded  <= '0;
         pkts_sent     <= '0;
      end else begin
         m_axis_tvalid <= tvalid_nxt;
         done          <= done_nxt;

         if (rd_en) begin
            m_axis_tdata <= mem_data[rd_idx];
            m_axis_tkeep <= mem_keep[rd_idx];
            // The final buffered beat always closes a frame.
            m_axis_tlast <= mem_last[rd_idx] || (rd_idx == last_idx);
            cur_idx      <= rd_idx;
            if ((rd_idx == last_idx) && !mem_last[rd_idx]) begin
               err_unterm <= 1'b1;
            end
         end

         if ((state == S_IDLE) && clear) begin
            beats_loaded <= '0;
            err_unterm   <= 1'b0;
         end else if (ld_fire) begin
            beats_loaded <= beats_loaded + CW'(1);
         end

         if (start_fire) begin
            pass         <= REP_WIDTH'(1);
            rep_q        <= (repeat_cnt == '0) ? REP_WIDTH'(1) : repeat_cnt;
            gap_q        <= gap_cycles;
            m_axis_tuser <= play_tuser;
            aborted      <= 1'b0;
         end else if (pass_inc) begin
            pass <= pass + REP_WIDTH'(1);
         end

         if (aborted_set) begin
            aborted <= 1'b1;
         end

         if (state == S_IDLE) begin
            abort_q <= 1'b0;
         end else if (abort) begin
            abort_q <= 1'b1;
         end

         if (gap_load) begin
            gap_cnt <= gap_q;
         end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
         end

         if (accept && m_axis_tlast) begin
            pkts_sent <= pkts_sent + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_axis_pkt_player.sv
// Testbench for axis_pkt_player (default parameters).
// A queue model of the replayed stream is built from the loaded beats;
// one negedge process compares every accepted beat, gap lengths and
// stall stability against it.

module tb_axis_pkt_player;

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic         ld_valid;
   logic         ld_ready;
   logic [511:0] ld_data;
   logic [63:0]  ld_keep;
   logic         ld_last;
   logic         clear;
   logic         start;
   logic         abort;
   logic [15:0]  gap_cycles;
   logic [7:0]   repeat_cnt;
   logic [127:0] play_tuser;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic         m_axis_tlast;
   logic         busy;
   logic         done;
   logic         aborted;
   logic         err_unterm;
   logic [6:0]   beats_loaded;
   logic [31:0]  pkts_sent;

   axis_pkt_player #(
      .DATA_WIDTH (512),
      .TUSER_WIDTH(128),
      .DEPTH      (64),
      .GAP_WIDTH  (16),
      .REP_WIDTH  (8)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_keep      (ld_keep),
      .ld_last      (ld_last),
      .clear        (clear),
      .start        (start),
      .abort        (abort),
      .gap_cycles   (gap_cycles),
      .repeat_cnt   (repeat_cnt),
      .play_tuser   (play_tuser),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .err_unterm   (err_unterm),
      .beats_loaded (beats_loaded),
      .pkts_sent    (pkts_sent)
   );

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   beat_t        buf_m[$];   // model of the loaded buffer
   beat_t        exp_q[$];   // expected replay stream
   logic [127:0] exp_tuser = '0;
   int           exp_gap   = 0;
   int           done_cnt  = 0;
   int           done_base = 0;
   int           n_beats   = 0;
   int           gap_checks = 0;
   bit           rdy_rand  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [511:0] mk_data(input int tag);
      logic [511:0] v;
      for (int w = 0; w < 16; w++) v[w*32 +: 32] = 32'(tag) * 32'h0001_0003 + 32'(w);
      return v;
   endfunction

   // ---------------- tready driver ----------------
   always @(posedge clk) begin
      #1;
      if (rdy_rand) m_axis_tready = ($urandom_range(0, 1) == 1);
      else          m_axis_tready = 1'b1;
   end

   // ---------------- compare process ----------------
   bit           stall_prev = 1'b0;
   logic [511:0] hold_d;
   logic [63:0]  hold_k;
   logic         hold_l;
   bit           in_gap  = 1'b0;
   int           gap_run = 0;
   beat_t        cmp_e;

   always @(negedge clk) begin
      if (!aresetn) begin
         stall_prev = 1'b0;
         in_gap     = 1'b0;
      end else begin
         if (stall_prev) begin
            n_checks++;
            if (m_axis_tvalid && m_axis_tdata === hold_d && m_axis_tkeep === hold_k && m_axis_tlast === hold_l)
               n_pass++;
            else
               $display("FAIL hold_stable: got valid=%0b last=%0b keep=%h expected valid=1 last=%0b keep=%h",
                        m_axis_tvalid, m_axis_tlast, m_axis_tkeep, hold_l, hold_k);
         end
         if (m_axis_tvalid) begin
            if (in_gap) begin
               chk("gap_len", 64'(gap_run), 64'(exp_gap));
               gap_checks++;
               in_gap = 1'b0;
            end
         end else if (in_gap) begin
            gap_run++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_beat: got beat with last=%0b expected no beat", m_axis_tlast);
            end else begin
               cmp_e = exp_q.pop_front();
               if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} === cmp_e) n_pass++;
               else $display("FAIL beat%0d: got data=%h keep=%h last=%0b expected data=%h keep=%h last=%0b",
                             n_beats, m_axis_tdata, m_axis_tkeep, m_axis_tlast, cmp_e.d, cmp_e.k, cmp_e.l);
               chk("beat_tuser", m_axis_tuser[63:0] ^ m_axis_tuser[127:64], exp_tuser[63:0] ^ exp_tuser[127:64]);
            end
            if (m_axis_tlast) begin
               in_gap  = 1'b1;
               gap_run = 0;
            end
         end
         if (done) begin
            done_cnt++;
            in_gap = 1'b0;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         hold_d = m_axis_tdata;
         hold_k = m_axis_tkeep;
         hold_l = m_axis_tlast;
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic load_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
      beat_t b;
      ld_data = d; ld_keep = k; ld_last = l; ld_valid = 1'b1;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      b.d = d; b.k = k; b.l = l;
      if (buf_m.size() < 64) buf_m.push_back(b);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      buf_m.delete();
   endtask

   // Builds the expected stream, pulses start and measures first-tvalid latency.
   // Returns at the negedge where the first beat is presented.
   task automatic start_play(input int gap, input int rep, input logic [127:0] tu, input int pkt_limit);
      int    n, r, pk, lat;
      bit    stop, got;
      beat_t b;
      n = buf_m.size();
      r = (rep == 0) ? 1 : rep;
      pk = 0; stop = 1'b0;
      exp_q.delete();
      for (int p = 0; p < r && !stop; p++) begin
         for (int i = 0; i < n && !stop; i++) begin
            b = buf_m[i];
            if (i == n - 1) b.l = 1'b1;
            exp_q.push_back(b);
            if (b.l) begin
               pk++;
               if (pkt_limit > 0 && pk >= pkt_limit) stop = 1'b1;
            end
         end
      end
      exp_gap   = gap;
      exp_tuser = tu;
      done_base = done_cnt;
      gap_cycles = 16'(gap); repeat_cnt = 8'(rep); play_tuser = tu;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (m_axis_tvalid) begin got = 1'b1; break; end
         lat++;
      end
      chk("start_latency", 64'(got ? lat : 99), 64'd2);
   endtask

   task automatic finish_run(input string tag, input int budget, input logic [31:0] pk,
                             input logic ab, input logic er);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      chk({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pkts_sent"}, 64'(pkts_sent), 64'(pk));
      chk({tag, "_aborted"}, 64'(aborted), 64'(ab));
      chk({tag, "_err_unterm"}, 64'(err_unterm), 64'(er));
   endtask

   // ---------------- main sequence ----------------
   int beats_base;
   int gaps_base;

   initial begin
      aresetn = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_keep = '0; ld_last = 1'b0;
      clear = 1'b0; start = 1'b0; abort = 1'b0;
      gap_cycles = '0; repeat_cnt = '0; play_tuser = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      chk("rst_err", 64'(err_unterm), 64'd0);
      chk("rst_beats", 64'(beats_loaded), 64'd0);
      chk("rst_pkts", 64'(pkts_sent), 64'd0);
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      @(negedge clk);
      chk("idle_ld_ready", 64'(ld_ready), 64'd1);
      @(posedge clk); #1;

      // 1: single two-beat config frame
      load_beat(mk_data(1), 64'hffffffffffffffff, 1'b0);
      load_beat(mk_data(2), 64'h00000000000fffff, 1'b1);
      chk("t1_beats_loaded", 64'(beats_loaded), 64'd2);
      start_play(0, 1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
      finish_run("t1", 50, 32'd1, 1'b0, 1'b0);

      // 2: eight frames, 30-cycle gaps
      do_clear();
      for (int f = 0; f < 8; f++) begin
         load_beat(mk_data(100 + 2 * f), 64'hffffffffffffffff, 1'b0);
         load_beat(mk_data(101 + 2 * f), 64'h00000000000fffff, 1'b1);
      end
      chk("t2_beats_loaded", 64'(beats_loaded), 64'd16);
      gaps_base = gap_checks;
      start_play(30, 1, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A, 0);
      finish_run("t2", 400, 32'd9, 1'b0, 1'b0);
      chk("t2_gaps_seen", 64'(gap_checks - gaps_base), 64'd7);

      // 3: random backpressure over a 3-beat frame, three passes
      do_clear();
      load_beat(mk_data(50), 64'h00000000000000ff, 1'b0);
      load_beat(mk_data(51), 64'hffffffffffffffff, 1'b0);
      load_beat(mk_data(52), 64'h000000000000000f, 1'b1);
      rdy_rand = 1'b1;
      beats_base = n_beats;
      start_play(2, 3, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003, 0);
      finish_run("t3", 300, 32'd12, 1'b0, 1'b0);
      chk("t3_beats_out", 64'(n_beats - beats_base), 64'd9);
      rdy_rand = 1'b0;

      // 4: full buffer, overflow attempt, three passes
      do_clear();
      for (int i = 0; i < 64; i++) load_beat(mk_data(200 + i), ~64'(i), (i % 4) == 3);
      ld_data = mk_data(999); ld_keep = 64'h1; ld_last = 1'b1; ld_valid = 1'b1;
      @(negedge clk);
      chk("t4_full_ld_ready", 64'(ld_ready), 64'd0);
      chk("t4_full_beats", 64'(beats_loaded), 64'd64);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      chk("t4_beats_after_extra", 64'(beats_loaded), 64'd64);
      beats_base = n_beats;
      start_play(0, 3, 128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0, 0);
      finish_run("t4", 400, 32'd60, 1'b0, 1'b0);
      chk("t4_beats_out", 64'(n_beats - beats_base), 64'd192);

      // 5: unterminated final beat
      do_clear();
      for (int i = 0; i < 3; i++) load_beat(mk_data(300 + i), 64'hffffffffffffffff, 1'b0);
      chk("t5_err_before", 64'(err_unterm), 64'd0);
      start_play(0, 1, 128'h5, 0);
      finish_run("t5", 50, 32'd61, 1'b0, 1'b1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      buf_m.delete();
      @(negedge clk);
      chk("t5_err_cleared", 64'(err_unterm), 64'd0);
      chk("t5_beats_cleared", 64'(beats_loaded), 64'd0);
      @(posedge clk); #1;

      // 6: abort during beat 0 of a 3-beat frame, repeat 5
      load_beat(mk_data(400), 64'hffffffffffffffff, 1'b0);
      load_beat(mk_data(401), 64'hffffffffffffffff, 1'b0);
      load_beat(mk_data(402), 64'h00000000000000ff, 1'b1);
      start_play(3, 5, 128'h6, 1);
      chk("t6_ld_ready_busy", 64'(ld_ready), 64'd0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      finish_run("t6", 50, 32'd62, 1'b1, 1'b0);

      // start with an empty buffer does nothing
      do_clear();
      done_base = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("empty_start_busy", 64'(busy), 64'd0);
      chk("empty_start_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("empty_start_done", 64'(done_cnt - done_base), 64'd0);
      chk("empty_start_aborted_held", 64'(aborted), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
